// File: rtl/ysyx_22050854_regfile_mp.sv
// Multi-port register file with a pending-writeback scoreboard and a halt freeze.
// Same-cycle write forwarding is enabled by defining YSYX_22050854_REGFILE_BYPASS_EN.
module ysyx_22050854_regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  input  logic                halt,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wr_act;
  logic            iss_act;

  assign wr_act  = wen && !halt && (waddr != '0);
  assign iss_act = issue_en && !halt && (issue_addr != '0);

  // A new issue outranks a writeback landing on the same register.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_act) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (iss_act) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  function automatic logic [XLEN-1:0] rd_val(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = (a == '0) ? '0 : regs_q[a];
`ifdef YSYX_22050854_REGFILE_BYPASS_EN
    if (wr_act && (a == waddr)) begin
      v = wdata;
    end
`endif
    return v;
  endfunction

  function automatic logic rd_busy(input logic [AW-1:0] a);
    logic b;
    b = (a == '0) ? 1'b0 : busy_q[a];
`ifdef YSYX_22050854_REGFILE_BYPASS_EN
    if (wr_act && (a == waddr)) begin
      b = iss_act && (issue_addr == a);
    end
`endif
    return b;
  endfunction

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      rdata[i*XLEN +: XLEN] = rd_val(raddr[i*AW +: AW]);
      rbusy[i]              = rd_busy(raddr[i*AW +: AW]);
    end
    dbg_data = rd_val(dbg_addr);
  end

endmodule

// File: tb/tb_ysyx_22050854_regfile_mp.sv
// Directed bench for ysyx_22050854_regfile_mp: array-based reference model plus pinned literal checks.
module tb_ysyx_22050854_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wen = 1'b0;
  logic [AW-1:0]       waddr = '0;
  logic [XLEN-1:0]     wdata = '0;
  logic [NRD*AW-1:0]   raddr = '0;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                issue_en = 1'b0;
  logic [AW-1:0]       issue_addr = '0;
  logic                halt = 1'b0;
  logic [AW-1:0]       dbg_addr = '0;
  logic [XLEN-1:0]     dbg_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];

  ysyx_22050854_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_en(issue_en), .issue_addr(issue_addr), .halt(halt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  end

  // Architectural state update: one edge applies reset, or (when not halted) the writeback then the issue.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else if (!halt) begin
      if (wen && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef YSYX_22050854_REGFILE_BYPASS_EN
    if (wen && !halt && waddr != 0 && a == waddr) return wdata;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef YSYX_22050854_REGFILE_BYPASS_EN
    if (wen && !halt && waddr != 0 && a == waddr) return issue_en && issue_addr == a;
`endif
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("model_rdata%0d", i), rdata[i*XLEN +: XLEN], exp_rd(raddr[i*AW +: AW]));
      check($sformatf("model_rbusy%0d", i), {63'd0, rbusy[i]}, {63'd0, exp_busy(raddr[i*AW +: AW])});
    end
    check("model_dbg", dbg_data, exp_rd(dbg_addr));
  endtask

  // Compare at the negedge, then drive the next cycle's controls.
  task automatic cyc(input logic r, input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                     input logic ie, input logic [AW-1:0] ia, input logic h);
    @(negedge clk);
    compare_all();
    #1;
    rst = r; wen = we; waddr = wa; wdata = wd; issue_en = ie; issue_addr = ia; halt = h;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic peek(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] ad);
    raddr = {a1, a0};
    dbg_addr = ad;
    #1;
    compare_all();
  endtask

  initial begin
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b1, 5'(k * 3), {$urandom, $urandom}, 1'b1, 5'(k + 20), 1'b0);
    end
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 1'b0);
    idle();
    peek(5'd3, 5'd21, 5'd6);
    cyc(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
    idle();
    peek(5'd3, 5'd21, 5'd6);
    check("rst_rdata0", rdata[63:0], 64'd0);
    check("rst_rdata1", rdata[127:64], 64'd0);
    check("rst_dbg", dbg_data, 64'd0);
    check("rst_rbusy", {62'd0, rbusy}, 64'd0);

    cyc(1'b0, 1'b1, 5'd0, 64'hDEAD_BEEF_0000_0001, 1'b1, 5'd0, 1'b0);
    idle();
    peek(5'd0, 5'd0, 5'd0);
    check("x0_rdata", rdata[63:0], 64'd0);
    check("x0_rbusy", {62'd0, rbusy}, 64'd0);

    cyc(1'b0, 1'b1, 5'd5, 64'h5, 1'b0, 5'd0, 1'b0);
    cyc(1'b0, 1'b1, 5'd6, 64'h6, 1'b0, 5'd0, 1'b0);
    idle();
    peek(5'd5, 5'd6, 5'd6);
    check("wr_x5", rdata[63:0], 64'h5);
    check("wr_x6", rdata[127:64], 64'h6);
    check("dbg_x6", dbg_data, 64'h6);

    cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 1'b0);
    idle();
    peek(5'd7, 5'd5, 5'd7);
    check("issue_x7_busy", {63'd0, rbusy[0]}, 64'd1);
    cyc(1'b0, 1'b1, 5'd7, 64'hA, 1'b1, 5'd7, 1'b0);
    idle();
    peek(5'd7, 5'd5, 5'd7);
    check("same_x7_busy", {63'd0, rbusy[0]}, 64'd1);
    check("same_x7_data", rdata[63:0], 64'hA);
    cyc(1'b0, 1'b1, 5'd7, 64'hB, 1'b1, 5'd12, 1'b0);
    idle();
    peek(5'd7, 5'd12, 5'd7);
    check("wb_x7_busy", {63'd0, rbusy[0]}, 64'd0);
    check("wb_x7_data", rdata[63:0], 64'hB);
    check("diff_x12_busy", {63'd0, rbusy[1]}, 64'd1);
    cyc(1'b0, 1'b1, 5'd13, 64'h13, 1'b0, 5'd0, 1'b0);
    idle();
    peek(5'd13, 5'd12, 5'd13);
    check("wb_nonbusy_busy", {63'd0, rbusy[0]}, 64'd0);
    check("wb_nonbusy_data", rdata[63:0], 64'h13);

    cyc(1'b0, 1'b1, 5'd8, 64'h8, 1'b1, 5'd9, 1'b1);
    cyc(1'b1 & 1'b0, 1'b1, 5'd12, 64'hFF, 1'b0, 5'd0, 1'b1);
    peek(5'd8, 5'd9, 5'd12);
    check("halt_x8", rdata[63:0], 64'd0);
    check("halt_x9_busy", {63'd0, rbusy[1]}, 64'd0);
    check("halt_x12_dbg", dbg_data, 64'd0);
    cyc(1'b0, 1'b1, 5'd8, 64'h8, 1'b0, 5'd0, 1'b0);
    idle();
    peek(5'd8, 5'd12, 5'd8);
    check("resume_x8", rdata[63:0], 64'h8);

    cyc(1'b0, 1'b1, 5'd10, 64'h10, 1'b0, 5'd0, 1'b0);
    peek(5'd10, 5'd8, 5'd10);
`ifdef YSYX_22050854_REGFILE_BYPASS_EN
    check("bypass_pre_edge", rdata[63:0], 64'h10);
`else
    check("nobypass_pre_edge", rdata[63:0], 64'd0);
`endif
    idle();
    peek(5'd10, 5'd8, 5'd10);
    check("post_edge_x10", rdata[63:0], 64'h10);

    cyc(1'b1, 1'b1, 5'd11, 64'h11, 1'b1, 5'd11, 1'b1);
    idle();
    peek(5'd11, 5'd12, 5'd10);
    check("rst_over_all_data", rdata[63:0], 64'd0);
    check("rst_over_all_busy", {62'd0, rbusy}, 64'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050854_regfile_mp.md
# ysyx_22050854_regfile_mp

Parametrised multi-port integer register file with a per-register pending-write scoreboard, replacing the fixed two-read-port register file inside `ysyx_22050854_cpu`. It provides NRD combinational read ports, one write port, and one debug probe port, which supersedes the hard-wired x5/x6 taps at the top level. It also tracks which registers have an outstanding multi-cycle writeback and supports a halt freeze on `ebreak`.

## Interface
Parameters:
- `XLEN`, 64, data width of each register.
- `NREG`, 32, number of architectural registers (power of two, ≥2).
- `NRD`, 2, number of read ports (1–4).
- `AW`, `$clog2(NREG)`, address width (derived; do not override).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wen`  in  1  write enable.
- `waddr`  in  AW  write address.
- `wdata`  in  XLEN  write data.
- `raddr`  in  NRD*AW  packed read addresses; port i = `[i*AW +: AW]`.
- `rdata`  out  NRD*XLEN  packed read data; port i = `[i*XLEN +: XLEN]`.
- `rbusy`  out  NRD  port i address has a pending write.
- `issue_en`  in  1  mark `issue_addr` as pending writeback.
- `issue_addr`  in  AW  register being issued.
- `halt`  in  1  freeze all state (driven from `ebreak`).
- `dbg_addr`  in  AW  debug probe address.
- `dbg_data`  out  XLEN  debug probe data.

## Operation
- Storage: `NREG` × `XLEN` registers plus an `NREG`-bit busy vector. Register 0 reads as 0 and is never busy.
- Write: on a rising edge with `wen=1`, `halt=0`, and `waddr≠0`, `regs[waddr] <= wdata`. Writes to address 0 are discarded.
- Read: `rdata[i]`, `dbg_data`, and `rbusy[i]` are combinational functions of the current address and state.
- Scoreboard, evaluated per edge when `halt=0`:
  - Set: `issue_en=1` and `issue_addr≠0` → `busy[issue_addr] <= 1`.
  - Clear: `wen=1` and `waddr≠0` → `busy[waddr] <= 0`.
  - Set and clear on the same address in the same cycle → busy = 1 (new issue wins).
  - Set and clear on different addresses → both take effect.
  - Issue to an already-busy register → stays 1, no error.
  - Writeback to a non-busy register → data written, busy stays 0.
- Halt: while `halt=1`, registers and busy bits hold their values, all write and issue inputs are ignored, and reads and debug reads continue to function.
- Reset: on an edge with `rst=1`, all registers are set to 0 and all busy bits to 0. Reset overrides `halt`, `wen`, and `issue_en`. After reset, every `rdata`, `dbg_data`, and `rbusy` reads 0.

## Timing
- Read latency: 0 cycles (combinational from address to data).
- Write latency: 1 cycle. Data written at edge N is visible on reads from just after edge N.
- Same-cycle read of an address being written returns the old value unless `REGFILE_BYPASS_EN` is defined (see Configuration).
- Busy set/clear takes effect at the edge. `rbusy` reflects the new value after that edge.
- Reset is synchronous: asserting `rst` mid-operation clears state at the next edge, and pending busy bits are lost.

## Configuration
- Macro: `YSYX_22050854_REGFILE_BYPASS_EN`.
- Defined: when `wen=1`, `halt=0`, and `waddr≠0`:
  - Any read port or `dbg_addr` equal to `waddr` returns `wdata` in the same cycle.
  - `rbusy` for that port reads 0 in the same cycle, unless `issue_en` targets the same address.
- Undefined: no forwarding. Reads return the stored value, and `rbusy` shows the registered busy bit.

## Test plan
- Reset: assert `rst` for 1 cycle after random writes → all `rdata`, `dbg_data`, and `rbusy` = 0.
- x0 protection: write `wdata=64'hDEAD_BEEF_0000_0001`, `waddr=0` → read port 0 with `raddr=0` returns 0. Issue to x0 → `rbusy` = 0.
- Write/read: write x5=`64'h5`, x6=`64'h6` on consecutive edges → `rdata` ports 0 and 1 = 5 and 6 next cycle, and `dbg_addr=6` → `dbg_data=6`.
- Scoreboard: issue x7 → `rbusy`=1 for `raddr=7`. Same-cycle issue x7 with writeback x7=`64'hA` → busy stays 1 and x7=`A`. Writeback x7=`64'hB` alone → busy 0 and x7=`B`.
- Halt: with `halt=1`, write x8=`64'h8` and issue x9 → x8 unchanged (0) and x9 not busy. Deassert `halt` → normal operation resumes.
- Bypass (macro defined): write x10=`64'h10` with `raddr0=10` in the same cycle → `rdata0=64'h10` before the edge. With the macro undefined → `rdata0=0` before the edge.
